// File: rtl/btn_bounce_gen.sv
// Emulates a raw mechanical button: a bouncing press, a stable hold, a bouncing release, then a done pulse.
// Define BOUNCE_RANDOM_EN to add a pseudo-random 0..15 cycle offset to each glitch half-width.
module btn_bounce_gen #(
  parameter int unsigned N_GLITCH   = 6,
  parameter int unsigned GLITCH_MIN = 10,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] hold_cyc,
  output logic        btn_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_BOUNCE,
    HOLD,
    REL_BOUNCE,
    DONE
  } state_t;

  state_t      state, state_nx;
  logic [16:0] half_cnt;
  logic [16:0] width;
  logic        phase;
  logic [7:0]  glitch;
  logic [31:0] hold_cnt;
  logic [31:0] hold_lat;
  logic [31:0] hold_last;
  logic        half_end;
  logic        pair_end;
  logic        last_pair;
  logic        hold_end;
  logic        bouncing;

`ifdef BOUNCE_RANDOM_EN
  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr;
  logic        lfsr_fb;

  always_comb begin
    lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    width   = 17'(GLITCH_MIN) + {13'd0, lfsr[3:0]};
  end

  // Steps only at the end of a pair so both halves share one width.
  always_ff @(posedge clk) begin
    if (reset)
      lfsr <= LFSR_INIT;
    else if (bouncing && pair_end)
      lfsr <= {lfsr[14:0], lfsr_fb};
  end
`else
  always_comb begin
    width = 17'(GLITCH_MIN);
  end
`endif

  always_comb begin
    bouncing  = (state == PRESS_BOUNCE) || (state == REL_BOUNCE);
    half_end  = (half_cnt == width - 17'd1);
    pair_end  = half_end && phase;
    last_pair = pair_end && (glitch == 8'(N_GLITCH - 1));
    // A zero hold request still spends one cycle in HOLD.
    hold_last = (hold_lat == '0) ? '0 : hold_lat - 32'd1;
    hold_end  = (hold_cnt == hold_last);
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    btn_out  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          state_nx = PRESS_BOUNCE;
      end
      PRESS_BOUNCE: begin
        busy    = 1'b1;
        btn_out = ~phase;
        if (last_pair)
          state_nx = HOLD;
      end
      HOLD: begin
        busy    = 1'b1;
        btn_out = 1'b1;
        if (hold_end)
          state_nx = REL_BOUNCE;
      end
      REL_BOUNCE: begin
        busy    = 1'b1;
        btn_out = phase;
        if (last_pair)
          state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      half_cnt <= '0;
      phase    <= 1'b0;
      glitch   <= '0;
      hold_cnt <= '0;
      hold_lat <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            hold_lat <= hold_cyc;
            half_cnt <= '0;
            phase    <= 1'b0;
            glitch   <= '0;
            hold_cnt <= '0;
          end
        end
        PRESS_BOUNCE, REL_BOUNCE: begin
          if (half_end) begin
            half_cnt <= '0;
            phase    <= ~phase;
            if (phase)
              glitch <= last_pair ? '0 : glitch + 8'd1;
          end else begin
            half_cnt <= half_cnt + 17'd1;
          end
        end
        HOLD: begin
          hold_cnt <= hold_end ? '0 : hold_cnt + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_bounce_gen.sv
// Scoreboard bench for btn_bounce_gen: a per-cycle {btn_out,busy,done} model is queued at each start
// and popped against the DUT every cycle; run-level checks cover busy length, edge count and done pulses.
module tb_btn_bounce_gen;

  localparam int N  = 6;
  localparam int GM = 10;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] hold_cyc;
  logic        btn_out;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  btn_bounce_gen #(
    .N_GLITCH  (N),
    .GLITCH_MIN(GM),
    .SEED      (SEED)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .hold_cyc(hold_cyc),
    .btn_out (btn_out),
    .busy    (busy),
    .done    (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0]  exp_q[$];
  logic        obs_q[$];
  int          exp_busy;
  logic [15:0] m_lfsr = SEED;
  int          r_busy, r_rises, r_done;

  task automatic next_w(output int w);
    w = GM;
`ifdef BOUNCE_RANDOM_EN
    w = GM + int'(m_lfsr[3:0]);
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    m_lfsr = SEED;
    exp_q.delete();
    @(negedge clk);
  endtask

  // Called at a negedge while idle; raises start for one posedge and queues the expected waveform.
  task automatic kick(input logic [31:0] h);
    int w;
    int hl;
    n_checks++;
    if ({btn_out, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL kick_idle: {btn,busy,done}=%b required 000", {btn_out, busy, done});
    end
    start    = 1'b1;
    hold_cyc = h;
    exp_busy = 0;
    for (int k = 0; k < N; k++) begin
      next_w(w);
      repeat (w) exp_q.push_back(3'b110);
      repeat (w) exp_q.push_back(3'b010);
      exp_busy += 2 * w;
    end
    hl = (h == 0) ? 1 : int'(h);
    repeat (hl) exp_q.push_back(3'b110);
    exp_busy += hl;
    for (int k = 0; k < N; k++) begin
      next_w(w);
      repeat (w) exp_q.push_back(3'b010);
      repeat (w) exp_q.push_back(3'b110);
      exp_busy += 2 * w;
    end
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b000);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_seq(input int mid_at, input bit done_poke);
    logic [2:0] e, o, fe, fo;
    int   mism  = 0;
    int   first = -1;
    int   i     = 0;
    logic prev  = 1'b0;
    r_busy = 0; r_rises = 0; r_done = 0;
    obs_q.delete();
    while (exp_q.size() > 0) begin
      if (i > 0) @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      o = {btn_out, busy, done};
      if (o !== e) begin
        mism++;
        if (first < 0) begin first = i; fe = e; fo = o; end
      end
      if (busy) begin r_busy++; obs_q.push_back(btn_out); end
      if (btn_out && !prev) r_rises++;
      prev = btn_out;
      if (done) r_done++;
      if (i == mid_at) begin start = 1'b1; hold_cyc = 32'd5; end
      if (done_poke && e[0]) start = 1'b1;
      i++;
    end
    n_checks++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL waveform: %0d bad cycles, first at %0d got %b required %b", mism, first, fo, fe);
    end
    n_checks++;
    if (r_busy != exp_busy) begin
      n_fail++;
      $display("FAIL busy_len: got %0d required %0d", r_busy, exp_busy);
    end
    n_checks++;
    if (r_rises != 2 * N + 1) begin
      n_fail++;
      $display("FAIL rising_edges: got %0d required %0d", r_rises, 2 * N + 1);
    end
    n_checks++;
    if (r_done != 1) begin
      n_fail++;
      $display("FAIL done_pulses: got %0d required 1", r_done);
    end
  endtask

  task automatic check_formula(input string name, input int h);
`ifndef BOUNCE_RANDOM_EN
    int want;
    want = 4 * N * GM + ((h == 0) ? 1 : h);
    n_checks++;
    if (r_busy != want) begin
      n_fail++;
      $display("FAIL %s_formula: busy %0d required %0d", name, r_busy, want);
    end
`endif
  endtask

  task automatic test_reset();
    start = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({btn_out, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_state: {btn,busy,done}=%b required 000", {btn_out, busy, done});
    end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_priority: busy=%b required 0", busy);
    end
  endtask

  task automatic test_basic();
    kick(32'd1000);
    run_seq(-1, 1'b0);
    check_formula("basic", 1000);
  endtask

  task automatic test_hold_zero();
    repeat (3) @(negedge clk);
    kick(32'd0);
    run_seq(-1, 1'b0);
    check_formula("hold_zero", 0);
  endtask

  task automatic test_start_while_busy();
    repeat (3) @(negedge clk);
    kick(32'd1000);
    run_seq(500, 1'b0);
    check_formula("start_busy", 1000);
  endtask

  task automatic test_start_at_done();
    repeat (3) @(negedge clk);
    kick(32'd3);
    run_seq(-1, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({btn_out, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL start_at_done: {btn,busy,done}=%b required 000", {btn_out, busy, done});
    end
  endtask

  task automatic test_reset_in_hold();
    repeat (3) @(negedge clk);
    kick(32'd1000);
    repeat (400) @(negedge clk);
    n_checks++;
    if ({btn_out, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL in_hold: {btn,busy}=%b required 11", {btn_out, busy});
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({btn_out, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid: {btn,busy,done}=%b required 000", {btn_out, busy, done});
    end
    reset  = 1'b0;
    m_lfsr = SEED;
    exp_q.delete();
    @(negedge clk);
    kick(32'd1000);
    run_seq(-1, 1'b0);
    check_formula("after_reset", 1000);
  endtask

  task automatic test_back_to_back();
    int b1;
    repeat (3) @(negedge clk);
    kick(32'd20);
    run_seq(-1, 1'b0);
    b1 = r_busy;
    kick(32'd20);
    run_seq(-1, 1'b0);
`ifndef BOUNCE_RANDOM_EN
    n_checks++;
    if (r_busy != b1) begin
      n_fail++;
      $display("FAIL back_to_back: second busy %0d required %0d", r_busy, b1);
    end
`endif
  endtask

`ifdef BOUNCE_RANDOM_EN
  task automatic press_runs(output int rl[2*N]);
    int   idx = 0;
    int   run = 0;
    logic cur;
    for (int j = 0; j < 2 * N; j++) rl[j] = 0;
    cur = obs_q[0];
    foreach (obs_q[j]) begin
      if (obs_q[j] == cur) run++;
      else begin
        if (idx < 2 * N) rl[idx] = run;
        idx++;
        cur = obs_q[j];
        run = 1;
      end
    end
  endtask

  task automatic test_random();
    int a[2*N];
    int b[2*N];
    do_reset();
    kick(32'd50);
    run_seq(-1, 1'b0);
    press_runs(a);
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (a[2*k] < GM || a[2*k] > GM + 15 || a[2*k] != a[2*k+1]) begin
        n_fail++;
        $display("FAIL rand_pair%0d: high %0d low %0d required equal in %0d..%0d",
                 k, a[2*k], a[2*k+1], GM, GM + 15);
      end
    end
    do_reset();
    kick(32'd50);
    run_seq(-1, 1'b0);
    press_runs(b);
    for (int k = 0; k < 2 * N; k++) begin
      n_checks++;
      if (b[k] != a[k]) begin
        n_fail++;
        $display("FAIL rand_repeat%0d: got %0d required %0d", k, b[k], a[k]);
      end
    end
  endtask
`endif

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    hold_cyc = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_hold_zero();
    test_start_while_busy();
    test_start_at_done();
    test_reset_in_hold();
    test_back_to_back();
`ifdef BOUNCE_RANDOM_EN
    test_random();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_bounce_gen.md
BTN_BOUNCE_GEN -- requirements
Module: btn_bounce_gen

Interface
REQ-001 The block SHALL have parameter N_GLITCH, default 6, giving the number of glitch pairs per edge (1..255).
REQ-002 The block SHALL have parameter GLITCH_MIN, default 10, giving the base glitch half-width in clock cycles (1..65535).
REQ-003 The block SHALL have parameter SEED, default 16'hACE1, giving the LFSR reset value.
REQ-004 The block SHALL have port clk, input, 1 bit, the system clock (100 MHz nominal).
REQ-005 The block SHALL have port reset, input, 1 bit, the synchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit, which requests one press/release sequence.
REQ-007 The block SHALL have port hold_cyc, input, 32 bits, giving the stable-pressed duration in cycles, latched when start is accepted.
REQ-008 The block SHALL have port btn_out, output, 1 bit, the emulated raw bouncing button level.
REQ-009 The block SHALL have port busy, output, 1 bit, which is high while a sequence is in progress.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking the end of a sequence.

Function
REQ-011 The state machine SHALL have the states IDLE, PRESS_BOUNCE, HOLD, REL_BOUNCE and DONE.
REQ-012 In IDLE, start=1 SHALL be accepted and hold_cyc latched, and the next cycle SHALL be in PRESS_BOUNCE with busy=1.
REQ-013 A start that arrives in any state other than IDLE SHALL be ignored; it SHALL NOT be queued and SHALL NOT change the latched hold_cyc.
REQ-014 In PRESS_BOUNCE, for each glitch k=0..N_GLITCH-1, btn_out SHALL be 1 for W_k cycles and then 0 for W_k cycles, with the first high cycle being the first PRESS_BOUNCE cycle.
REQ-015 In HOLD, btn_out SHALL be 1 for max(hold_cyc,1) cycles.
REQ-016 In REL_BOUNCE, for each glitch k, btn_out SHALL be 0 for W_k cycles and then 1 for W_k cycles.
REQ-017 After the last REL_BOUNCE glitch, the block SHALL enter DONE for exactly one cycle with btn_out=0, done=1 and busy=0, and SHALL then return to IDLE.
REQ-018 busy SHALL be high for exactly the sum of the PRESS_BOUNCE, HOLD and REL_BOUNCE cycles.
REQ-019 With fixed widths, that busy duration SHALL equal 4*N_GLITCH*GLITCH_MIN + max(hold_cyc,1).
REQ-020 Each sequence SHALL produce N_GLITCH+1 rising edges on btn_out during press and N_GLITCH rising edges during release.
REQ-021 The half-width counter SHALL be 17 bits wide, and the hold counter SHALL be 32 bits wide and SHALL NOT wrap within a sequence.
REQ-022 In IDLE, btn_out SHALL be 0, busy SHALL be 0 and done SHALL be 0.
REQ-023 A start that coincides with the DONE cycle SHALL be ignored; start is accepted only in IDLE.

Reset
REQ-024 reset=1 SHALL force IDLE, btn_out=0, busy=0 and done=0 at the next clock edge, from any state including mid-sequence.
REQ-025 reset SHALL load the LFSR with SEED, or with 16'h0001 if SEED is 0, and SHALL clear all counters and the latched hold_cyc.
REQ-026 reset SHALL take priority over start in the same cycle.

Configuration
REQ-027 When macro BOUNCE_RANDOM_EN is defined, W_k SHALL equal GLITCH_MIN + lfsr[3:0].
REQ-028 The LFSR SHALL be a 16-bit Fibonacci LFSR with taps 16,14,13,11, and SHALL advance exactly once per glitch pair (W_k is constant within a pair).
REQ-029 When BOUNCE_RANDOM_EN is undefined, W_k SHALL equal GLITCH_MIN for all k, and no LFSR SHALL be instantiated.

Verification
REQ-030 Fixed mode, N=6, GLITCH_MIN=10, hold_cyc=1000, start pulse -> btn_out rises 1 cycle after start; busy is high for 1240 cycles; done pulses once; 13 rising edges on btn_out in total.
REQ-031 Fixed mode, hold_cyc=0 -> HOLD lasts 1 cycle; busy is high for 241 cycles.
REQ-032 A start pulse while busy (for example at cycle 500 of a sequence) -> no effect on the timing; exactly one done pulse is produced.
REQ-033 reset asserted during HOLD -> the next cycle shows btn_out=0, busy=0 and done=0; a following start produces a full, correct sequence.
REQ-034 BOUNCE_RANDOM_EN defined, SEED=16'hACE1 -> every half-width lies in 10..25; both halves of each pair are equal; the width sequence is identical after re-reset.
REQ-035 Back-to-back operation with start asserted in the cycle after done -> the second sequence is accepted and its timing matches the first.
